// File: rtl/jk_pkg.sv
// Shared types and the per-bit JK excitation rule for the JK bank driver.
package jk_pkg;

  // J/K command pair, bit 1 is J and bit 0 is K.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } jk_drv_state_t;

  // Minimal excitation: don't-cares resolve to 0, so toggle is never produced
  // and a bit that already matches its target is left on hold.
  function automatic jk_cmd_t jk_excite(input logic q, input logic t);
    jk_cmd_t cmd;
    case ({q, t})
      2'b01:   cmd = SET;
      2'b10:   cmd = RST;
      default: cmd = HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational WIDTH-wide J/K excitation from current Q and target pattern.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  jk_cmd_t cmd;

  // Apply the per-bit excitation rule across the whole word.
  always_comb begin
    j   = '0;
    k   = '0;
    cmd = HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      cmd  = jk_pkg::jk_excite(q[i], tgt[i]);
      j[i] = cmd[1];
      k[i] = cmd[0];
    end
  end

endmodule

// File: rtl/jk_excite_drv.sv
// Command-side driver for a JK flip-flop bank: accepts a target word, drives
// one cycle of excitation, reads the bank back and retries a bounded number
// of times before reporting done or err.
module jk_excite_drv
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tgt_valid,
  output logic                           tgt_ready,
  input  logic [WIDTH-1:0]               tgt_data,
  input  logic [WIDTH-1:0]               q_fb,
  output logic [WIDTH-1:0]               j_out,
  output logic [WIDTH-1:0]               k_out,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int CNT_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

  jk_drv_state_t    state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rdy_en_q;
  logic [WIDTH-1:0] j_raw, k_raw;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q   (q_fb),
    .tgt (tgt_q),
    .j   (j_raw),
    .k   (k_raw)
  );

  // ready is held low through reset and rises on the first edge after release
  assign tgt_ready = (state_q == IDLE) && rdy_en_q;
  assign busy      = (state_q != IDLE);
  // Excitation only reaches the bank during DRIVE; everywhere else the bank holds.
  assign j_out     = (state_q == DRIVE) ? j_raw : '0;
  assign k_out     = (state_q == DRIVE) ? k_raw : '0;
  assign done      = done_q;
  assign err       = err_q;
  assign retry_cnt = cnt_q;

  // Next-state, target latch, retry counter and status pulse decode.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          tgt_d   = tgt_data;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q < MAX_CNT) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_excite_drv.sv
// Self-checking bench for jk_excite_drv with a behavioural JK bank and
// per-bit stuck-at-0 fault injection on set operations.
module tb_jk_excite_drv;

  localparam int WIDTH     = 8;
  localparam int MAX_RETRY = 3;
  localparam int CW        = $clog2(MAX_RETRY + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tgt_valid = 1'b0;
  logic [7:0]    tgt_data = 8'h00;
  logic          tgt_ready;
  logic [7:0]    q_fb, j_out, k_out;
  logic          busy, done, err;
  logic [CW-1:0] retry_cnt;

  int n_pass = 0;
  int n_total = 0;

  jk_excite_drv #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .q_fb      (q_fb),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank with preload and stuck-at-0 on sets.
  logic [7:0] bank;
  logic       preload_en = 1'b0;
  logic [7:0] preload_val = 8'h00;
  logic [7:0] stuck_mask = 8'h00;
  int         stuck_limit = 0;
  int         stuck_hits;

  assign q_fb = bank;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank       <= 8'h00;
      stuck_hits <= 0;
    end else if (preload_en) begin
      bank       <= preload_val;
      stuck_hits <= 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        case ({j_out[i], k_out[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: ;
        endcase
        if (j_out[i] && stuck_mask[i] && (stuck_hits < stuck_limit)) bank[i] <= 1'b0;
      end
      if (((j_out & stuck_mask) != 8'h00) && (stuck_hits < stuck_limit))
        stuck_hits <= stuck_hits + 1;
    end
  end

  // Observations of the last transaction.
  logic [7:0]    jo [0:20];
  logic [7:0]    ko [0:20];
  int            stat_cyc;
  logic          stat_done, stat_err;
  logic [CW-1:0] stat_cnt;
  logic [7:0]    stat_bank;
  logic          toggle_seen;
  int            done_cnt, err_cnt, nz_j_cycles;

  task automatic set_bank(input logic [7:0] v);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_val = v;
    @(posedge clk);
    #1 preload_en = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] t);
    int w;
    w = 0;
    @(negedge clk);
    while (!tgt_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    tgt_valid = 1'b1;
    tgt_data  = t;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    tgt_data  = 8'($urandom);
    stat_cyc = -1; stat_done = 1'b0; stat_err = 1'b0; stat_cnt = '0; stat_bank = 8'h00;
    toggle_seen = 1'b0; done_cnt = 0; err_cnt = 0; nz_j_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      jo[k] = j_out;
      ko[k] = k_out;
      if ((j_out & k_out) != 8'h00) toggle_seen = 1'b1;
      if (j_out != 8'h00) nz_j_cycles++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((done || err) && stat_cyc < 0) begin
        stat_cyc = k; stat_done = done; stat_err = err; stat_cnt = retry_cnt; stat_bank = bank;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({tgt_ready, busy, done, err} !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", {tgt_ready, busy, done, err});
    else n_pass++;
    n_total++;
    if ({j_out, k_out} !== 16'h0000) $display("FAIL reset_jk: got %h want 0000", {j_out, k_out});
    else n_pass++;
    n_total++;
    if (retry_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", retry_cnt);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (tgt_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", tgt_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (tgt_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", tgt_ready);
    else n_pass++;
  endtask

  task automatic test_basic_set();
    set_bank(8'h00);
    run_txn(8'hA5);
    n_total++;
    if (jo[1] !== 8'hA5 || ko[1] !== 8'h00) $display("FAIL basic_drive: j=%h k=%h want j=a5 k=00", jo[1], ko[1]);
    else n_pass++;
    n_total++;
    if (jo[2] !== 8'h00 || ko[2] !== 8'h00) $display("FAIL basic_check_hold: j=%h k=%h want 00", jo[2], ko[2]);
    else n_pass++;
    n_total++;
    if (stat_cyc !== 3 || stat_done !== 1'b1) $display("FAIL basic_done: cyc=%0d done=%b want 3 1", stat_cyc, stat_done);
    else n_pass++;
    n_total++;
    if (stat_cnt !== CW'(0) || stat_bank !== 8'hA5) $display("FAIL basic_result: cnt=%0d bank=%h want 0 a5", stat_cnt, stat_bank);
    else n_pass++;
  endtask

  task automatic test_mixed();
    set_bank(8'hF0);
    run_txn(8'h3C);
    n_total++;
    if (jo[1] !== 8'h0C || ko[1] !== 8'hC0) $display("FAIL mixed_drive: j=%h k=%h want j=0c k=c0", jo[1], ko[1]);
    else n_pass++;
    n_total++;
    if (stat_cyc !== 3 || stat_done !== 1'b1 || stat_bank !== 8'h3C) $display("FAIL mixed_done: cyc=%0d done=%b bank=%h want 3 1 3c", stat_cyc, stat_done, stat_bank);
    else n_pass++;
    n_total++;
    if (toggle_seen !== 1'b0) $display("FAIL mixed_toggle: got %b want 0", toggle_seen);
    else n_pass++;
    n_total++;
    if (((jo[1] | ko[1]) & ~(8'hF0 ^ 8'h3C)) !== 8'h00) $display("FAIL mixed_disturb: got %h want 00", (jo[1] | ko[1]) & ~(8'hF0 ^ 8'h3C));
    else n_pass++;
  endtask

  task automatic test_noop();
    logic [7:0] acc;
    set_bank(8'h5A);
    run_txn(8'h5A);
    acc = 8'h00;
    for (int k = 1; k <= 20; k++) acc = acc | jo[k] | ko[k];
    n_total++;
    if (acc !== 8'h00) $display("FAIL noop_jk: got %h want 00", acc);
    else n_pass++;
    n_total++;
    if (stat_cyc !== 3 || stat_done !== 1'b1 || stat_bank !== 8'h5A) $display("FAIL noop_done: cyc=%0d done=%b bank=%h want 3 1 5a", stat_cyc, stat_done, stat_bank);
    else n_pass++;
  endtask

  task automatic test_retry();
    stuck_mask = 8'h01; stuck_limit = 1;
    set_bank(8'h00);
    run_txn(8'h01);
    n_total++;
    if (jo[1] !== 8'h01 || jo[2] !== 8'h00 || jo[3] !== 8'h01) $display("FAIL retry_drives: j1=%h j2=%h j3=%h want 01 00 01", jo[1], jo[2], jo[3]);
    else n_pass++;
    n_total++;
    if (stat_cyc !== 5 || stat_done !== 1'b1 || stat_cnt !== CW'(1)) $display("FAIL retry_done: cyc=%0d done=%b cnt=%0d want 5 1 1", stat_cyc, stat_done, stat_cnt);
    else n_pass++;
    n_total++;
    if (stat_bank !== 8'h01) $display("FAIL retry_bank: got %h want 01", stat_bank);
    else n_pass++;
  endtask

  task automatic test_exhaust();
    stuck_mask = 8'h01; stuck_limit = 1000;
    set_bank(8'h00);
    run_txn(8'h01);
    n_total++;
    if (nz_j_cycles !== 4) $display("FAIL exhaust_drives: got %0d want 4", nz_j_cycles);
    else n_pass++;
    n_total++;
    if (stat_cyc !== 9 || stat_err !== 1'b1 || stat_cnt !== CW'(MAX_RETRY)) $display("FAIL exhaust_err: cyc=%0d err=%b cnt=%0d want 9 1 %0d", stat_cyc, stat_err, stat_cnt, MAX_RETRY);
    else n_pass++;
    n_total++;
    if (done_cnt !== 0 || err_cnt !== 1) $display("FAIL exhaust_pulses: done=%0d err=%0d want 0 1", done_cnt, err_cnt);
    else n_pass++;
    n_total++;
    if (retry_cnt !== CW'(MAX_RETRY)) $display("FAIL exhaust_cnt_hold: got %0d want %0d", retry_cnt, MAX_RETRY);
    else n_pass++;
    stuck_mask = 8'h00; stuck_limit = 0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int ph = 1; ph <= 2; ph++) begin
      set_bank(8'h00);
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_data  = 8'h0F;
      @(posedge clk);
      #1 tgt_valid = 1'b0;
      for (int c = 0; c < ph; c++) @(negedge clk);
      n_total++;
      if (busy !== 1'b1) $display("FAIL rstmid_busy_pre ph%0d: got %b want 1", ph, busy);
      else n_pass++;
      #1 reset = 1'b0;
      #1;
      n_total++;
      if ({j_out, k_out} !== 16'h0000 || busy !== 1'b0 || tgt_ready !== 1'b0) $display("FAIL rstmid_abort ph%0d: jk=%h busy=%b rdy=%b want 0000 0 0", ph, {j_out, k_out}, busy, tgt_ready);
      else n_pass++;
      pulses = 0;
      repeat (2) begin
        @(negedge clk);
        if (done || err) pulses++;
      end
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (tgt_ready !== 1'b0) $display("FAIL rstmid_ready_early ph%0d: got %b want 0", ph, tgt_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (tgt_ready !== 1'b1) $display("FAIL rstmid_ready ph%0d: got %b want 1", ph, tgt_ready);
      else n_pass++;
      repeat (4) begin
        @(negedge clk);
        if (done || err) pulses++;
      end
      n_total++;
      if (pulses !== 0) $display("FAIL rstmid_no_status ph%0d: got %0d pulses want 0", ph, pulses);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int acc[0:1];
    int dn[0:3];
    int n, dc;
    n = 0; dc = 0;
    acc[0] = -1; acc[1] = -1;
    for (int i = 0; i < 4; i++) dn[i] = -1;
    set_bank(8'h00);
    tgt_valid = 1'b1;
    tgt_data  = 8'h11;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done) begin
        if (dc < 4) dn[dc] = c;
        dc++;
      end
      if (tgt_valid && tgt_ready && n < 2) begin
        acc[n] = c;
        n++;
      end
      @(posedge clk);
      #1;
      if (n == 1) tgt_data = 8'h22;
      else if (n >= 2) tgt_valid = 1'b0;
    end
    n_total++;
    if (n !== 2 || (acc[1] - acc[0]) !== 3) $display("FAIL b2b_accept: n=%0d gap=%0d want 2 3", n, acc[1] - acc[0]);
    else n_pass++;
    n_total++;
    if (dc !== 2 || dn[0] !== acc[0] + 3 || dn[1] !== acc[0] + 6) $display("FAIL b2b_done: cnt=%0d at %0d,%0d want 2 at %0d,%0d", dc, dn[0], dn[1], acc[0] + 3, acc[0] + 6);
    else n_pass++;
    n_total++;
    if (bank !== 8'h22) $display("FAIL b2b_bank: got %h want 22", bank);
    else n_pass++;
  endtask

  // Random transactions against an attempt-level model of the bank and driver.
  task automatic test_random();
    logic [7:0] q0, t, q, need, smask;
    int lim, hits, att, exp_cyc;
    logic ok;
    for (int it = 0; it < 40; it++) begin
      q0    = 8'($urandom);
      t     = ($urandom_range(0, 7) == 0) ? q0 : 8'($urandom);
      smask = ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      lim   = $urandom_range(0, 5);
      q = q0; hits = 0; att = 0; ok = 1'b0;
      for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
        att  = a + 1;
        need = t & ~q & smask;
        if (hits < lim && need != 8'h00) begin
          q = t & ~need;
          hits++;
        end else begin
          q = t;
        end
        ok = (q == t);
      end
      exp_cyc = 2 * att + 1;
      stuck_mask = smask; stuck_limit = lim;
      set_bank(q0);
      run_txn(t);
      n_total++;
      if (jo[1] !== (~q0 & t) || ko[1] !== (q0 & ~t)) $display("FAIL rand_drive it%0d: j=%h k=%h want j=%h k=%h", it, jo[1], ko[1], ~q0 & t, q0 & ~t);
      else n_pass++;
      n_total++;
      if (stat_cyc !== exp_cyc || stat_done !== ok || stat_err !== ~ok) $display("FAIL rand_status it%0d: cyc=%0d done=%b err=%b want %0d %b %b", it, stat_cyc, stat_done, stat_err, exp_cyc, ok, ~ok);
      else n_pass++;
      n_total++;
      if (stat_cnt !== CW'(att - 1) || stat_bank !== q) $display("FAIL rand_result it%0d: cnt=%0d bank=%h want %0d %h", it, stat_cnt, stat_bank, att - 1, q);
      else n_pass++;
      n_total++;
      if (toggle_seen !== 1'b0 || (done_cnt + err_cnt) !== 1) $display("FAIL rand_pulses it%0d: tgl=%b pulses=%0d want 0 1", it, toggle_seen, done_cnt + err_cnt);
      else n_pass++;
    end
    stuck_mask = 8'h00; stuck_limit = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_set();
    test_mixed();
    test_noop();
    test_retry();
    test_exhaust();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jk_excite_drv.md
# jk_excite_drv

Command-side driver for a bank of WIDTH JK flip-flops sharing one clock. It accepts a target word over a valid/ready handshake and computes per-bit J/K excitation from the bank's current Q feedback. It applies that excitation for one cycle, then reads the bank back and reports done or error, retrying a bounded number of times. It sits between control logic and the JK storage bank, which it drives.

## Interface
- `WIDTH`, default 8: number of JK bits driven.
- `MAX_RETRY`, default 3: extra drive attempts allowed after the first failed check.
- `clk` in 1: rising-edge clock, shared with the JK bank.
- `reset` in 1: asynchronous, active-low reset.
- `tgt_valid` in 1: target word offered.
- `tgt_ready` out 1: block can accept a target.
- `tgt_data` in WIDTH: desired Q pattern.
- `q_fb` in WIDTH: Q outputs of the JK bank.
- `j_out` out WIDTH: J inputs to the bank.
- `k_out` out WIDTH: K inputs to the bank.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse; bank matched the target.
- `err` out 1: one-cycle pulse; retries exhausted without a match.
- `retry_cnt` out $clog2(MAX_RETRY+1): drive attempts beyond the first in the last or current transaction.

## Operation
- Reset values (while `reset`=0): state IDLE, `tgt_ready`=0, `j_out`=`k_out`=0, `busy`=`done`=`err`=0, `retry_cnt`=0, target register=0.
- FSM states are IDLE, DRIVE and CHECK.
- **IDLE**
  - `tgt_ready`=1 and `j_out`/`k_out`=0.
  - When `tgt_valid`&`tgt_ready` at a clock edge: latch `tgt_data`, clear `retry_cnt`, go to DRIVE.
- **DRIVE**
  - Drive the per-bit excitation from the `q_fb` sampled this cycle and the latched target.
  - Then go to CHECK.
- **CHECK**
  - Drive `j_out`/`k_out`=0 (hold) and compare `q_fb` with the latched target.
  - Equal: pulse `done` and go to IDLE.
  - Unequal and `retry_cnt`<MAX_RETRY: increment `retry_cnt` and go to DRIVE.
  - Unequal and `retry_cnt`=MAX_RETRY: pulse `err` and go to IDLE.
- Excitation per bit, written as (q, t) -> (J, K):
  - (0, 0) -> (0, 0) hold
  - (0, 1) -> (1, 0) set
  - (1, 1) -> (0, 0) hold
  - (1, 0) -> (0, 1) reset
  - Don't-cares resolve to 0, so J=K=1 (toggle) is never emitted. Bits already correct are never disturbed.
- `busy`=1 in DRIVE and CHECK.
- `tgt_data` is ignored unless accepted. The latched target does not change during a transaction.
- `retry_cnt` holds its final value after `done`/`err` until the next acceptance.
- A target equal to the current Q still takes the full path: DRIVE emits all-zero J/K.

## Timing
- All outputs are registered; `tgt_ready`, `busy`, `j_out` and `k_out` are decoded from registered state and the target/feedback registers.
- Accept edge at T0: DRIVE during cycle T0+1, CHECK during T0+2.
- `done`/`err` are high during cycle T0+3, coincident with IDLE and `tgt_ready`=1.
- Each retry adds 2 cycles.
- Worst-case transaction length is 2·(MAX_RETRY+1)+1 cycles to the status pulse.
- A new target may be accepted in the same cycle that `done`/`err` is high. Back-to-back throughput is one target per 3 cycles with no retries.
- The bank updates Q on the edge ending DRIVE, so `q_fb` in CHECK reflects that drive.
- `reset` assertion mid-transaction immediately (asynchronously) forces IDLE and zero J/K. No `done`/`err` is generated for the aborted transaction.
- `tgt_ready` rises at the first clock edge after `reset` deasserts.

## Structure
- Shared package `jk_pkg` holds:
  - `jk_cmd_t` enum: HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11.
  - FSM state enum `jk_drv_state_t`.
  - Function `jk_excite(q, t)` returning `jk_cmd_t`.
- One sub-module, `jk_excite`: combinational, WIDTH-wide, maps (`q_fb`, target) to (`j_out`, `k_out`) by calling `jk_excite` per bit.
- The bench instantiates WIDTH behavioral JK flops on `j_out`/`k_out`/`reset`, feeding `q_fb`, with a per-bit fault-injection override.

## Test plan
- **Basic set:** bank=8'h00, target 8'hA5 at T0. Require:
  - `j_out`=8'hA5 and `k_out`=8'h00 at T0+1.
  - `done` at T0+3, `retry_cnt`=0, bank=8'hA5.
- **Mixed:** bank=8'hF0, target 8'h3C. Require:
  - J=8'h0C and K=8'hC0 in DRIVE.
  - `done` after 3 cycles.
  - Bits 7:6 and 1:0, and 5:4 and 3:2, are never driven with J=K=1.
- **No-op:** bank=8'h5A, target 8'h5A. Require J=K=0 throughout, `done` at T0+3, Q unchanged.
- **Retry then success:** force bit 0 stuck at 0 for the first attempt only, target 8'h01. Require:
  - Second DRIVE at T0+3.
  - `done` at T0+5 with `retry_cnt`=1.
- **Exhaustion:** bit 0 stuck at 0 permanently, target 8'h01, MAX_RETRY=3. Require:
  - Four DRIVE cycles.
  - `err` at T0+9 with `retry_cnt`=3.
  - `done` never asserted.
- **Reset and back-to-back:**
  - `reset` low during CHECK: J/K=0 at once, no status pulse, `tgt_ready`=1 one edge after release.
  - Targets 8'h11 then 8'h22 offered continuously: accepted 3 cycles apart, two `done` pulses.
